// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle control unit for the RISC-IV datapath.
// Accepts one opcode per instr_valid/instr_ready handshake and walks it
// through DECODE, EXEC or MEM, then WB. It stalls in MEM on mem_ready and
// aborts after MEM_TIMEOUT cycles (0 = wait forever).
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   instr_valid/ready  opcode handshake; ready is high only in IDLE
//   opcode             instruction opcode, captured on handshake
//   mem_ready          memory completed current access (used in MEM only)
//   reg_write, alu_src, mem_read, mem_write, mem_to_reg, alu_opn
//                      datapath controls, Moore decodes of state/opcode
//   done, illegal, timeout
//                      single-cycle status pulses shown in the IDLE cycle
//                      that follows retirement, discard or abort
module cu_multicycle #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned NUM_ALU_OPS = 7,
  parameter int unsigned LOAD_OP     = 7,
  parameter int unsigned STORE_OP    = 8,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                reg_write,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic [ALUOP_W-1:0]  alu_opn,
  output logic                done,
  output logic                illegal,
  output logic                timeout
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OPCODE_W-1:0] r_opcode;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_illegal;
  logic                r_timeout;
  logic                w_done_nxt;
  logic                w_illegal_nxt;
  logic                w_timeout_nxt;
  logic                w_is_alu;
  logic                w_is_load;
  logic                w_is_store;
  logic                w_cnt_last;

  assign w_is_alu   = (32'(r_opcode) < NUM_ALU_OPS);
  assign w_is_load  = (32'(r_opcode) == LOAD_OP);
  assign w_is_store = (32'(r_opcode) == STORE_OP);
  // With MEM_TIMEOUT == 0 the counter is free-running and never matches.
  assign w_cnt_last = (MEM_TIMEOUT != 0) && (32'(r_cnt) == MEM_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_opcode  <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
      r_timeout <= w_timeout_nxt;
      if (r_state == S_IDLE && instr_valid) begin
        r_opcode <= opcode;
      end
      // Held at zero outside MEM, so it is already clear on MEM entry.
      if (r_state != S_MEM) begin
        r_cnt <= '0;
      end else if (!mem_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = 1'b0;
    w_illegal_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_alu) begin
          w_state_nxt = S_EXEC;
        end else if (w_is_load || w_is_store) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt   = S_IDLE;
          w_illegal_nxt = 1'b1;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
      end
      S_MEM: begin
        // mem_ready takes priority over the timeout on the last allowed cycle.
        if (mem_ready) begin
          if (w_is_load) begin
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (w_cnt_last) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    instr_ready = (r_state == S_IDLE) && !rst;
    reg_write   = 1'b0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_opn     = '0;
    case (r_state)
      S_EXEC: begin
        alu_opn = r_opcode[ALUOP_W-1:0];
      end
      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = w_is_load;
        mem_write = w_is_store;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_load;
        alu_opn    = w_is_alu ? r_opcode[ALUOP_W-1:0] : '0;
      end
      default: begin
      end
    endcase
  end

  assign done    = r_done;
  assign illegal = r_illegal;
  assign timeout = r_timeout;

endmodule
